// File: rtl/codec_init_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : codec_init_sequencer
//  Description : Walks a fixed register-init table into an audio codec by
//                issuing one write transaction per entry to a downstream
//                i2c_controller, with a startup delay, inter-write gaps and
//                per-handshake timeouts.
//  Revision    : 1.0 - initial release
// ============================================================================
module codec_init_sequencer #(
  parameter logic [6:0] PERIPH_ADDR   = 7'h1A,
  parameter int         NUM_WRITES    = 8,
  parameter int         STARTUP_DELAY = 1000,
  parameter int         GAP_DELAY     = 16,
  parameter int         TIMEOUT       = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] i2c_state,
  output logic       i2c_enable,
  output logic       i2c_mode,
  output logic [6:0] i2c_periph_addr,
  output logic [7:0] i2c_byte,
  output logic [2:0] index,
  output logic       busy,
  output logic       done,
  output logic       error
);

  // Delay counter only needs to reach (delay - 1); timeout counter saturates
  // at TIMEOUT itself, so it needs one extra code point.
  localparam int DLY_MAX = (STARTUP_DELAY > GAP_DELAY) ? STARTUP_DELAY : GAP_DELAY;
  localparam int DW      = (DLY_MAX < 2) ? 1 : $clog2(DLY_MAX);
  localparam int TW      = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  // A zero delay still spends one cycle in the waiting state.
  localparam logic [DW-1:0] STARTUP_LAST = DW'((STARTUP_DELAY > 0) ? STARTUP_DELAY - 1 : 0);
  localparam logic [DW-1:0] GAP_LAST     = DW'((GAP_DELAY > 0) ? GAP_DELAY - 1 : 0);
  localparam logic [TW-1:0] TO_LAST      = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [TW-1:0] TO_MAX       = TW'((TIMEOUT > 0) ? TIMEOUT : 0);

  // Out-of-range table sizes fall back to the full table.
  localparam logic [2:0] LAST_INDEX =
    3'((NUM_WRITES >= 1 && NUM_WRITES <= 8) ? NUM_WRITES - 1 : 7);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_STARTUP     = 3'd1,
    S_ISSUE       = 3'd2,
    S_WAIT_ACCEPT = 3'd3,
    S_WAIT_DONE   = 3'd4,
    S_GAP         = 3'd5,
    S_DONE        = 3'd6,
    S_ERROR       = 3'd7
  } state_t;

  state_t        state;
  logic [DW-1:0] delay_cnt;
  logic [TW-1:0] to_cnt;
  logic [TW-1:0] to_cnt_inc;

  // Every transfer is a write to the same codec address.
  assign i2c_mode        = 1'b1;
  assign i2c_periph_addr = PERIPH_ADDR;

  // Saturating increment so a stalled handshake never wraps the counter.
  assign to_cnt_inc = (to_cnt == TO_MAX) ? to_cnt : to_cnt + 1'b1;

  // Init table lookup for the entry currently being sent.
  always_comb begin
    case (index)
      3'd0:    i2c_byte = 8'h1E;
      3'd1:    i2c_byte = 8'h00;
      3'd2:    i2c_byte = 8'h0C;
      3'd3:    i2c_byte = 8'h00;
      3'd4:    i2c_byte = 8'h0E;
      3'd5:    i2c_byte = 8'h42;
      3'd6:    i2c_byte = 8'h12;
      default: i2c_byte = 8'h01;
    endcase
  end

  // Sequencer FSM; all status outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      index      <= '0;
      delay_cnt  <= '0;
      to_cnt     <= '0;
      i2c_enable <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state     <= S_STARTUP;
            index     <= '0;
            delay_cnt <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
            busy      <= 1'b1;
          end
        end

        S_STARTUP: begin
          if (delay_cnt >= STARTUP_LAST) begin
            state      <= S_ISSUE;
            delay_cnt  <= '0;
            i2c_enable <= 1'b1;
          end else begin
            delay_cnt <= delay_cnt + 1'b1;
          end
        end

        // Enable is already high; the controller gets at least this cycle
        // to see it before acceptance is monitored.
        S_ISSUE: begin
          state  <= S_WAIT_ACCEPT;
          to_cnt <= '0;
        end

        S_WAIT_ACCEPT: begin
          if (i2c_state != 4'd0) begin
            state      <= S_WAIT_DONE;
            to_cnt     <= '0;
            i2c_enable <= 1'b0;
          end else begin
            to_cnt <= to_cnt_inc;
            if (to_cnt >= TO_LAST) begin
              state      <= S_ERROR;
              i2c_enable <= 1'b0;
              busy       <= 1'b0;
              error      <= 1'b1;
            end
          end
        end

        S_WAIT_DONE: begin
          if (i2c_state == 4'd0) begin
            state     <= S_GAP;
            delay_cnt <= '0;
          end else begin
            to_cnt <= to_cnt_inc;
            if (to_cnt >= TO_LAST) begin
              state <= S_ERROR;
              busy  <= 1'b0;
              error <= 1'b1;
            end
          end
        end

        S_GAP: begin
          if (delay_cnt >= GAP_LAST) begin
            delay_cnt <= '0;
            if (index == LAST_INDEX) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              index      <= index + 1'b1;
              state      <= S_ISSUE;
              i2c_enable <= 1'b1;
            end
          end else begin
            delay_cnt <= delay_cnt + 1'b1;
          end
        end

        default: begin
          state      <= S_IDLE;
          i2c_enable <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_codec_init_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_codec_init_sequencer
//  Description : Self-checking bench for codec_init_sequencer with a
//                behavioural i2c_controller model and timing reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_codec_init_sequencer;

  localparam int         STARTUP_DELAY = 4;
  localparam int         GAP_DELAY     = 2;
  localparam int         TIMEOUT       = 50;
  localparam int         NUM_WRITES    = 8;
  localparam logic [6:0] PERIPH_ADDR   = 7'h1A;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] i2c_state;
  logic       i2c_enable;
  logic       i2c_mode;
  logic [6:0] i2c_periph_addr;
  logic [7:0] i2c_byte;
  logic [2:0] index;
  logic       busy;
  logic       done;
  logic       error;

  logic [7:0] ref_tab [0:7] = '{8'h1E, 8'h00, 8'h0C, 8'h00, 8'h0E, 8'h42, 8'h12, 8'h01};

  int total  = 0;
  int passes = 0;
  int tick   = 0;

  codec_init_sequencer #(
    .PERIPH_ADDR   (PERIPH_ADDR),
    .NUM_WRITES    (NUM_WRITES),
    .STARTUP_DELAY (STARTUP_DELAY),
    .GAP_DELAY     (GAP_DELAY),
    .TIMEOUT       (TIMEOUT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .i2c_state       (i2c_state),
    .i2c_enable      (i2c_enable),
    .i2c_mode        (i2c_mode),
    .i2c_periph_addr (i2c_periph_addr),
    .i2c_byte        (i2c_byte),
    .index           (index),
    .busy            (busy),
    .done            (done),
    .error           (error)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
    tick = tick + 1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total = total + 1;
    assert (obs === exp) passes = passes + 1;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // mode 0: well-behaved controller, 1: never accepts, 2: hangs busy on entry 3
  // fixed: nominal timing (accept at once, 20 busy cycles) instead of random
  // dup_idx: pulse start while that entry is issued; rst_idx: reset in its WAIT_DONE
  task automatic run_seq(input int mode, input bit fixed, input int dup_idx, input int rst_idx);
    int st_tick, rise_tick, drv_tick, ret_tick, exp_acc, pulses, phase, cnt, hold;
    bit prev_en, stuck, finished;
    pulses = 0; phase = 0; cnt = 0; hold = 0;
    rise_tick = 0; drv_tick = 0; ret_tick = 0; exp_acc = 0;
    prev_en = 1'b0; stuck = 1'b0; finished = 1'b0;
    i2c_state = 4'd0;
    start = 1'b1;
    st_tick = tick;
    step();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_done_clr", done, 0);
    chk("start_err_clr", error, 0);
    for (int n = 0; n < 4000 && !finished; n++) begin
      start = 1'b0;
      // enable rising: a new transaction for the next table entry
      if (i2c_enable && !prev_en) begin
        if (pulses == 0) chk("startup_lat", tick - st_tick, STARTUP_DELAY + 1);
        else             chk("gap_lat", tick - ret_tick, GAP_DELAY + 1);
        if (pulses < NUM_WRITES) begin
          chk("pulse_index", index, pulses);
          chk("pulse_byte", i2c_byte, ref_tab[pulses]);
        end else begin
          chk("extra_pulse", pulses, NUM_WRITES - 1);
        end
        rise_tick = tick;
        pulses    = pulses + 1;
        if (pulses - 1 == dup_idx) start = 1'b1;
      end
      // enable falling: controller acceptance observed
      if (!i2c_enable && prev_en && !error) begin
        chk("enable_drop_lat", tick, exp_acc);
        if (pulses - 1 == rst_idx) begin
          reset = 1'b1;
          step();
          reset = 1'b0;
          i2c_state = 4'd0;
          chk("rst_enable", i2c_enable, 0);
          chk("rst_index", index, 0);
          chk("rst_busy", busy, 0);
          chk("rst_done", done, 0);
          chk("rst_error", error, 0);
          chk("rst_byte", i2c_byte, 8'h1E);
          finished = 1'b1;
        end
      end
      if (!finished && done) begin
        chk("done_lat", tick - ret_tick, GAP_DELAY + 1);
        chk("done_pulses", pulses, NUM_WRITES);
        chk("done_index", index, NUM_WRITES - 1);
        chk("done_busy", busy, 0);
        chk("done_error", error, 0);
        chk("done_enable", i2c_enable, 0);
        finished = 1'b1;
      end else if (!finished && error) begin
        if (mode == 1) begin
          chk("acc_timeout_lat", tick - rise_tick, TIMEOUT + 1);
          chk("acc_timeout_idx", index, 0);
        end else if (mode == 2) begin
          chk("cmp_timeout_lat", tick - exp_acc, TIMEOUT);
          chk("cmp_timeout_idx", index, 3);
        end else begin
          chk("unexpected_error", error, 0);
        end
        chk("err_enable", i2c_enable, 0);
        chk("err_busy", busy, 0);
        chk("err_done", done, 0);
        finished = 1'b1;
      end
      // controller model
      if (!finished) begin
        if (phase == 0 && i2c_enable && mode != 1) begin
          cnt   = fixed ? 0 : int'($urandom_range(0, 3));
          phase = 1;
        end
        if (phase == 1) begin
          if (cnt == 0) begin
            hold      = fixed ? 20 : int'($urandom_range(2, 25));
            stuck     = (mode == 2 && pulses - 1 == 3);
            i2c_state = stuck ? 4'd7 : 4'($urandom_range(1, 15));
            drv_tick  = tick;
            exp_acc   = ((drv_tick > rise_tick) ? drv_tick : rise_tick + 1) + 1;
            phase     = 2;
          end else begin
            cnt = cnt - 1;
          end
        end else if (phase == 2 && !stuck) begin
          hold = hold - 1;
          if (hold == 0) begin
            i2c_state = 4'd0;
            ret_tick  = tick;
            phase     = 0;
          end
        end
        prev_en = i2c_enable;
        step();
      end
    end
    chk("run_finished", finished, 1);
    i2c_state = 4'd0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b1;
    i2c_state = 4'd0;
    repeat (3) step();
    reset = 1'b0;
    start = 1'b0;
    step();
    chk("reset_enable", i2c_enable, 0);
    chk("reset_index", index, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_error", error, 0);
    chk("reset_byte", i2c_byte, 8'h1E);
    chk("reset_mode", i2c_mode, 1);
    chk("reset_addr", i2c_periph_addr, 7'h1A);

    run_seq(0, 1'b1, -1, -1);
    repeat (3) step();
    chk("done_sticky", done, 1);
    chk("idle_busy", busy, 0);

    run_seq(0, 1'b0, 2, -1);
    run_seq(0, 1'b0, -1, -1);
    run_seq(1, 1'b0, -1, -1);
    repeat (3) step();
    chk("error_sticky", error, 1);
    run_seq(2, 1'b0, -1, -1);
    run_seq(0, 1'b0, -1, 5);
    run_seq(0, 1'b0, -1, -1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
`default_nettype wire
